// File: rtl/sp_mem_responder.sv
// Load/store responder for a Gowin single-port block RAM (32-bit words, no byte enables).
// One request in flight at a time; partial-word stores run as read-modify-write.
module sp_mem_responder #(
   parameter int ADDR_W       = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W+1:0] req_addr_i,
   input  logic [3:0]        req_wstrb_i,
   input  logic [31:0]       req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_rdata_o,
   output logic              mem_reset_o,
   output logic              mem_ce_o,
   output logic              mem_oce_o,
   output logic              mem_wre_o,
   output logic [ADDR_W-1:0] mem_ad_o,
   output logic [31:0]       mem_din_o,
   input  logic [31:0]       mem_dout_i,
   output logic [2:0]        state_o
);

   // Handshake: a transfer happens on a cycle where valid && ready are both high
   // at the rising edge; valid and payload hold steady until that cycle.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_ISSUE = 3'd3,
      RESP     = 3'd4
   } state_t;

   localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                store_q, store_d;
   logic [3:0]          wstrb_q, wstrb_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic [ADDR_W-1:0]   mem_ad_q, mem_ad_d;
   logic [31:0]         mem_din_q, mem_din_d;
   logic [31:0]         merge;
   logic                accept;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^req_addr_i[1:0];
   assign accept           = req_valid_i && req_ready_o;

   always_comb begin
      merge = 32'd0;
      for (int i = 0; i < 4; i++) begin
         merge[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem_dout_i[8*i +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      store_d     = store_q;
      wstrb_d     = wstrb_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      mem_ad_d    = mem_ad_q;
      mem_din_d   = mem_din_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               store_d = req_we_i;
               wstrb_d = req_wstrb_i;
               wdata_d = req_wdata_i;
               if (!req_we_i) begin
                  mem_ad_d = req_addr_i[ADDR_W+1:2];
                  state_d  = RD_ISSUE;
               end else if (req_wstrb_i == 4'hF) begin
                  mem_ad_d  = req_addr_i[ADDR_W+1:2];
                  mem_din_d = req_wdata_i;
                  state_d   = WR_ISSUE;
               end else if (req_wstrb_i == 4'h0) begin
                  rsp_rdata_d = 32'd0;
                  state_d     = RESP;
               end else begin
                  mem_ad_d = req_addr_i[ADDR_W+1:2];
                  state_d  = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: begin
            cnt_d   = 2'd0;
            state_d = RD_WAIT;
         end
         RD_WAIT: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_WAIT) begin
               if (store_q) begin
                  mem_din_d = merge;
                  state_d   = WR_ISSUE;
               end else begin
                  rsp_rdata_d = mem_dout_i;
                  state_d     = RESP;
               end
            end
         end
         WR_ISSUE: begin
            rsp_rdata_d = 32'd0;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         store_q     <= 1'b0;
         wstrb_q     <= 4'd0;
         wdata_q     <= 32'd0;
         rsp_rdata_q <= 32'd0;
         mem_ad_q    <= '0;
         mem_din_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         store_q     <= store_d;
         wstrb_q     <= wstrb_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_ad_q    <= mem_ad_d;
         mem_din_q   <= mem_din_d;
      end
   end

   // Strobes are masked during reset so an aborted operation never touches the RAM.
   assign req_ready_o = (state_q == IDLE) && !reset_i;
   assign rsp_valid_o = (state_q == RESP) && !reset_i;
   assign mem_ce_o    = ((state_q == RD_ISSUE) || (state_q == RD_WAIT) || (state_q == WR_ISSUE)) && !reset_i;
   assign mem_wre_o   = (state_q == WR_ISSUE) && !reset_i;
   assign mem_oce_o   = (state_q == RD_WAIT) && (READ_LATENCY == 2) && !reset_i;
   assign mem_reset_o = reset_i;
   assign rsp_rdata_o = rsp_rdata_q;
   assign mem_ad_o    = mem_ad_q;
   assign mem_din_o   = mem_din_q;
   assign state_o     = state_q;

endmodule
